// File: rtl/vector_packer.sv
// vector_packer: gathers a lane-serial scalar stream into N-lane vectors.
// Each completed vector sits in an output register until the consumer
// accepts it. A second completed vector can wait in the accumulator, and
// while it waits the scalar source is held off.
// Optional feature macro: VECTOR_PACKER_ZERO_PAD_EN. When it is defined,
// the accumulator is cleared after every move, so lanes left unwritten in a
// short vector read as 0.

module vector_packer_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] out_q
);
  logic [DATA_WIDTH-1:0] acc_q;

  // Accumulator lane plus its output lane. A scalar that closes the vector
  // bypasses the accumulator and goes straight into the output lane.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      if (load) out_q <= wr ? din : acc_q;
      if (clr)     acc_q <= '0;
      else if (wr) acc_q <= din;
    end
  end
endmodule

module vector_packer #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic [1:0]            in_eof,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] vector_out [N-1:0],
  output logic                  enqueue,
  output logic [1:0]            eof_out,
  input  logic                  out_ready
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] idx;
  logic          acc_closed;
  logic [1:0]    acc_eof;
  logic          accept, closing, out_free, move_acc, move_new, load, clr;

  assign in_ready = ~acc_closed;
  assign accept   = in_valid && in_ready;
  assign closing  = accept && ((idx == LAST) || (in_eof != 2'b00));
  assign out_free = !enqueue || out_ready;
  assign move_acc = acc_closed && out_free;
  assign move_new = closing && out_free;
  assign load     = move_acc || move_new;

`ifdef VECTOR_PACKER_ZERO_PAD_EN
  assign clr = load;
`else
  assign clr = 1'b0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic wr;
    assign wr = accept && (idx == IW'(i));
    vector_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (wr),
      .clr     (clr),
      .load    (load),
      .din     (in_data),
      .out_q   (vector_out[i])
    );
  end

  // Lane index, parked-vector flag and output-register valid/tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      acc_closed <= 1'b0;
      acc_eof    <= 2'b00;
      enqueue    <= 1'b0;
      eof_out    <= 2'b00;
    end else begin
      if (closing) begin
        idx     <= '0;
        acc_eof <= in_eof;
      end else if (accept) begin
        idx <= idx + 1'b1;
      end
      if (move_acc)                 acc_closed <= 1'b0;
      else if (closing && !out_free) acc_closed <= 1'b1;
      enqueue <= load || (enqueue && !out_ready);
      if (load) eof_out <= move_acc ? acc_eof : in_eof;
    end
  end
endmodule

// File: tb/tb_vector_packer.sv
// Self-checking bench for vector_packer: a cycle table, directed sequences
// and random traffic, all checked against a queue-based scoreboard.
module tb_vector_packer;
  localparam int N  = 16;
  localparam int DW = 32;
`ifdef VECTOR_PACKER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct { vec_t data; logic [1:0] eof; } exp_t;
  typedef struct {
    logic v; logic [DW-1:0] d; logic [1:0] e; logic ordy;
    logic x_enq; logic x_rdy; logic [1:0] x_eof; logic [DW-1:0] x_l0; logic [DW-1:0] x_l1;
  } row_t;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_eof = 2'b00;
  logic          in_ready, enqueue;
  logic [DW-1:0] vector_out [N-1:0];
  logic [1:0]    eof_out;
  wire           out_ready;
  logic          or_val = 1'b1, tog = 1'b0, rnd = 1'b0;
  int            mode = 0;
  int            checks = 0, errors = 0;

  exp_t          q[$];
  vec_t          mem;
  int            cnt;

  assign out_ready = (mode == 1) ? tog : (mode == 2) ? rnd : or_val;

  vector_packer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_eof(in_eof), .in_ready(in_ready), .vector_out(vector_out),
    .enqueue(enqueue), .eof_out(eof_out), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    rnd = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t cur_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = vector_out[i];
    return v;
  endfunction

  // Scoreboard: pending vectors live in q. Output register is q[0];
  // source is held off only while two vectors are pending.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outs", {enqueue, eof_out, in_ready}, {1'b0, 2'b00, 1'b1});
      chk("reset_vec", cur_vec(), '0);
      q.delete();
      mem = '0;
      cnt = 0;
    end else begin
      chk("sb_enqueue", enqueue, q.size() > 0);
      chk("sb_in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("sb_vector", cur_vec(), q[0].data);
        chk("sb_eof", eof_out, q[0].eof);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        mem[cnt] = in_data;
        cnt++;
        if (cnt == N || in_eof != 2'b00) begin
          q.push_back('{data: mem, eof: in_eof});
          cnt = 0;
          if (PAD) mem = '0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [1:0] e);
    int n = 0;
    logic r;
    in_data = d; in_eof = e; in_valid = 1'b1;
    do begin
      r = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 300);
    chk("send_timeout", r, 1'b1);
    in_valid = 1'b0; in_eof = 2'b00;
  endtask

  task automatic drain();
    int n = 0;
    mode = 0; or_val = 1'b1;
    while (enqueue && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain", enqueue, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    row_t tbl[8];
    logic [DW-1:0] l1b = PAD ? 32'd0 : 32'd8;
    tbl[0] = '{1'b1, 32'd7,  2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd0,  32'd0};
    tbl[1] = '{1'b1, 32'd8,  2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd0,  32'd0};
    tbl[2] = '{1'b1, 32'd9,  2'd2, 1'b1, 1'b1, 1'b1, 2'd2, 32'd7,  32'd8};
    tbl[3] = '{1'b1, 32'd20, 2'd3, 1'b0, 1'b1, 1'b0, 2'd2, 32'd7,  32'd8};
    tbl[4] = '{1'b1, 32'd21, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd7,  32'd8};
    tbl[5] = '{1'b0, 32'd0,  2'd0, 1'b1, 1'b1, 1'b1, 2'd3, 32'd20, l1b};
    tbl[6] = '{1'b1, 32'd21, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 32'd21, l1b};
    tbl[7] = '{1'b0, 32'd0,  2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 32'd21, l1b};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Cycle table: early closes, a parked vector, 1-lane vector
    foreach (tbl[r]) begin
      in_valid = tbl[r].v; in_data = tbl[r].d; in_eof = tbl[r].e; or_val = tbl[r].ordy;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_ctl", r), {enqueue, in_ready, eof_out},
          {tbl[r].x_enq, tbl[r].x_rdy, tbl[r].x_eof});
      chk($sformatf("tbl%0d_lanes", r), {vector_out[0], vector_out[1]}, {tbl[r].x_l0, tbl[r].x_l1});
    end
    in_valid = 1'b0; in_eof = 2'b00; or_val = 1'b1;

    // Full vector 1..16, one-cycle enqueue pulse
    for (int i = 1; i <= N; i++) send(DW'(i), (i == N) ? 2'b01 : 2'b00);
    chk("full_enq", enqueue, 1'b1);
    chk("full_lanes", {vector_out[0], vector_out[15], eof_out}, {32'd1, 32'd16, 2'b01});
    @(posedge clk); #1;
    chk("full_pulse_end", enqueue, 1'b0);

    // Backpressure: two vectors pending, then released in order
    or_val = 1'b0;
    for (int i = 0; i < 2 * N; i++) send(DW'(i), 2'b00);
    chk("bp_hold", {in_ready, enqueue}, {1'b0, 1'b1});
    chk("bp_a", vector_out[0], 32'd0);
    or_val = 1'b1;
    @(posedge clk); #1;
    chk("bp_b", {enqueue, in_ready, vector_out[0]}, {1'b1, 1'b1, 32'd16});
    @(posedge clk); #1;
    chk("bp_done", enqueue, 1'b0);

    // Reset in the middle of a vector
    for (int i = 0; i < 5; i++) send(DW'(60 + i), 2'b00);
    reset_n = 1'b0;
    #1 chk("rst_async", {enqueue, in_ready, eof_out}, {1'b1 ^ 1'b1, 1'b1, 2'b00});
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) send(DW'(100 + i), 2'b00);
    chk("rst_vec", {enqueue, vector_out[0], vector_out[15]}, {1'b1, 32'd100, 32'd115});
    @(posedge clk); #1;
    chk("rst_one_vec", enqueue, 1'b0);

    // Partial vector after a full one: stale vs. padded lanes
    for (int i = 1; i <= N; i++) send(DW'(i), 2'b00);
    send(32'd50, 2'b00);
    send(32'd51, 2'b01);
    chk("part_lanes", {vector_out[0], vector_out[1], vector_out[2], vector_out[15]},
        {32'd50, 32'd51, PAD ? 32'd0 : 32'd3, PAD ? 32'd0 : 32'd16});
    drain();

    // Consumer toggling out_ready every cycle over three vectors
    mode = 1;
    for (int i = 0; i < 3 * N; i++) send(DW'(200 + i), 2'b00);
    drain();

    // Random traffic and random consumer
    mode = 2;
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send($urandom, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    drain();
    repeat (2) begin @(posedge clk); #1; end
    chk("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
